// File: rtl/user_type.sv
// Shared SHA-256 message-schedule types, K constants and small-sigma helpers.
package user_type;

    localparam int unsigned W_WIDTH     = 32;
    localparam int unsigned WIN_DEPTH   = 16;
    localparam int unsigned BLOCK_WIDTH = WIN_DEPTH * W_WIDTH;
    localparam int unsigned ROUNDS      = 64;
    localparam int unsigned IDX_WIDTH   = 6;

    typedef logic [W_WIDTH-1:0] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Round constants: first 32 bits of the fractional parts of the cube roots of the first 64 primes.
    localparam word_t SHA256_K [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // s0(x) = rotr7 ^ rotr18 ^ shr3
    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // s1(x) = rotr17 ^ rotr19 ^ shr10
    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Combinational next schedule word: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t] (mod 2^32).
module sha256_w_next
    import user_type::*;
(
    input  logic [W_WIDTH-1:0] w0_i,
    input  logic [W_WIDTH-1:0] w1_i,
    input  logic [W_WIDTH-1:0] w9_i,
    input  logic [W_WIDTH-1:0] w14_i,
    output logic [W_WIDTH-1:0] w16_o
);

    // Four-operand modular sum; carries out of bit 31 are dropped by the word width.
    assign w16_o = small_sigma1(w14_i) + w9_i + small_sigma0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule producer: accepts one 512-bit block, streams W[0..63] with a
// valid/ready handshake. Optional K[t] output is enabled by defining SHA256_KOUT_EN.
module sha256_msg_schedule
    import user_type::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    input  logic [BLOCK_WIDTH-1:0] blk_data,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [W_WIDTH-1:0]     w,
    output logic [IDX_WIDTH-1:0]   w_idx,
    output logic                   w_last
`ifdef SHA256_KOUT_EN
    ,
    output logic [W_WIDTH-1:0]     k
`endif
);

    localparam logic [IDX_WIDTH-1:0] T_LAST     = IDX_WIDTH'(ROUNDS - 1);
    localparam logic [IDX_WIDTH-1:0] T_PRE_LAST = IDX_WIDTH'(ROUNDS - 2);

    state_e                 state_q, state_d;
    word_t                  win_q [WIN_DEPTH];
    word_t                  win_d [WIN_DEPTH];
    logic [IDX_WIDTH-1:0]   t_q, t_d;
    logic                   blk_ready_q, blk_ready_d;
    logic                   w_valid_q, w_valid_d;
    logic                   w_last_q, w_last_d;
    word_t                  w_next;
`ifdef SHA256_KOUT_EN
    word_t                  k_q, k_d;
`endif

    sha256_w_next u_w_next (
        .w0_i  (win_q[0]),
        .w1_i  (win_q[1]),
        .w9_i  (win_q[9]),
        .w14_i (win_q[14]),
        .w16_o (w_next)
    );

    // Next-state: load window on block accept, shift/extend and advance t on each word handshake.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        t_d         = t_q;
        blk_ready_d = blk_ready_q;
        w_valid_d   = w_valid_q;
        w_last_d    = w_last_q;
`ifdef SHA256_KOUT_EN
        k_d         = k_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (blk_valid && blk_ready_q) begin
                    for (int unsigned i = 0; i < WIN_DEPTH; i++) begin
                        win_d[i] = blk_data[W_WIDTH*(WIN_DEPTH-1-i) +: W_WIDTH];
                    end
                    state_d     = ST_RUN;
                    t_d         = '0;
                    blk_ready_d = 1'b0;
                    w_valid_d   = 1'b1;
                    w_last_d    = 1'b0;
`ifdef SHA256_KOUT_EN
                    k_d         = SHA256_K[0];
`endif
                end
            end
            ST_RUN: begin
                if (w_ready) begin
                    for (int unsigned i = 0; i < WIN_DEPTH - 1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[WIN_DEPTH-1] = w_next;
                    if (t_q == T_LAST) begin
                        state_d     = ST_IDLE;
                        t_d         = '0;
                        blk_ready_d = 1'b1;
                        w_valid_d   = 1'b0;
                        w_last_d    = 1'b0;
                    end else begin
                        t_d      = t_q + 1'b1;
                        w_last_d = (t_q == T_PRE_LAST);
`ifdef SHA256_KOUT_EN
                        k_d      = SHA256_K[t_q + 1'b1];
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    // State, window, counter and output registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int unsigned i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= '0;
            end
            t_q         <= '0;
            blk_ready_q <= 1'b1;
            w_valid_q   <= 1'b0;
            w_last_q    <= 1'b0;
`ifdef SHA256_KOUT_EN
            k_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            t_q         <= t_d;
            blk_ready_q <= blk_ready_d;
            w_valid_q   <= w_valid_d;
            w_last_q    <= w_last_d;
`ifdef SHA256_KOUT_EN
            k_q         <= k_d;
`endif
        end
    end

    assign blk_ready = blk_ready_q;
    assign w_valid   = w_valid_q;
    assign w         = win_q[0];
    assign w_idx     = t_q;
    assign w_last    = w_last_q;
`ifdef SHA256_KOUT_EN
    assign k         = k_q;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed + random bench for sha256_msg_schedule against a plain-array schedule model.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w;
    logic [5:0]   w_idx;
    logic         w_last;
`ifdef SHA256_KOUT_EN
    logic [31:0]  k;
    logic [31:0]  prev_k;
    int           prev_t = -1;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  exp_w [64];
    bit           is_abc  = 1'b0;

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w         (w),
        .w_idx     (w_idx),
        .w_last    (w_last)
`ifdef SHA256_KOUT_EN
        ,
        .k         (k)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule computed straight from the recurrence over a 64-entry array.
    task automatic build_exp(input logic [511:0] b);
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
            s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
            exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
        end
    endtask

    task automatic check_word(input int t);
        chk("w_valid", w_valid, 1);
        chk("blk_ready_run", blk_ready, 0);
        chk("w_idx", w_idx, t);
        chk("w", w, exp_w[t]);
        chk("w_last", w_last, (t == 63));
        if (is_abc && t == 16) chk("abc_w16", w, 32'h61626380);
        if (is_abc && t == 17) chk("abc_w17", w, 32'h000f0000);
`ifdef SHA256_KOUT_EN
        if (t == 0)  chk("k0", k, 32'h428a2f98);
        if (t == 63) chk("k63", k, 32'hc67178f2);
        if (t == prev_t) chk("k_hold", k, prev_k);
        prev_k = k;
        prev_t = t;
`endif
    endtask

    task automatic send_block(input logic [511:0] b, input bit hold);
        int waited;
        waited = 0;
        while (blk_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        chk("send_blk_ready", blk_ready, 1);
        blk_data  = b;
        blk_valid = 1'b1;
        tick();
        if (!hold) blk_valid = 1'b0;
    endtask

    task automatic recv(input int n_words, input int max_stall, input logic [511:0] b);
        int stalls;
        build_exp(b);
`ifdef SHA256_KOUT_EN
        prev_t = -1;
`endif
        for (int t = 0; t < n_words; t++) begin
            stalls = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            for (int s = 0; s < stalls; s++) begin
                w_ready = 1'b0;
                check_word(t);
                tick();
            end
            w_ready = 1'b1;
            check_word(t);
            tick();
        end
        w_ready = 1'b0;
        if (n_words == 64) begin
            chk("post_w_valid", w_valid, 0);
            chk("post_blk_ready", blk_ready, 1);
            chk("post_w_last", w_last, 0);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        logic [511:0] abc;
        logic [511:0] b1;
        logic [511:0] b2;
        abc       = {32'h61626380, 448'h0, 32'h00000018};
        rst       = 1'b1;
        blk_valid = 1'b0;
        w_ready   = 1'b0;
        blk_data  = '0;

        // Reset values
        #12;
        chk("rst_blk_ready", blk_ready, 1);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w", w, 0);
        chk("rst_w_idx", w_idx, 0);
        chk("rst_w_last", w_last, 0);
`ifdef SHA256_KOUT_EN
        chk("rst_k", k, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();

        // "abc" block at full rate, then with random consumer stalls
        is_abc = 1'b1;
        send_block(abc, 1'b0);
        recv(64, 0, abc);
        send_block(abc, 1'b0);
        recv(64, 3, abc);
        is_abc = 1'b0;

        // blk_valid held through RUN: second block waits for the last-word handshake
        b1 = rand_block();
        b2 = rand_block();
        send_block(b1, 1'b1);
        blk_data = b2;
        recv(64, 0, b1);
        tick();
        blk_valid = 1'b0;
        recv(64, 0, b2);

        // Asynchronous reset mid-block at t=30
        send_block(abc, 1'b0);
        recv(30, 0, abc);
        chk("pre_rst_idx", w_idx, 30);
        rst = 1'b1;
        #2;
        chk("arst_w_valid", w_valid, 0);
        chk("arst_blk_ready", blk_ready, 1);
        chk("arst_w_idx", w_idx, 0);
        chk("arst_w", w, 0);
        rst = 1'b0;
        tick();
        b1 = rand_block();
        send_block(b1, 1'b0);
        recv(64, 1, b1);

        // Random blocks against the reference model
        for (int n = 0; n < 400; n++) begin
            b1 = rand_block();
            send_block(b1, 1'b0);
            recv(64, (n % 4 == 0) ? 2 : 0, b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
